// File: rtl/mem_fifo_pkg.sv
// Shared constants and types for the FIFO controller in front of the 8x15 dual-port memory.
package mem_fifo_pkg;

    localparam int unsigned DATA_W = 15;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mem_fifo_ptr.sv
// Wrapping memory pointer with increment enable; wraps naturally on WIDTH-bit overflow.
module mem_fifo_ptr
    import mem_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller driving an external dual-port memory (write on port A, registered read on B).
// Optional almost_full/almost_empty outputs are built when MEM_FIFO_LEVELS_EN is defined.
module mem_fifo_ctrl #(
    parameter int unsigned DATA_W   = mem_fifo_pkg::DATA_W,
    parameter int unsigned ADDR_W   = mem_fifo_pkg::ADDR_W
`ifdef MEM_FIFO_LEVELS_EN
    ,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 1
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              mem_enA,
    output logic [ADDR_W-1:0] mem_addrA,
    output logic [DATA_W-1:0] mem_dataA,
    output logic              mem_enB,
    output logic [ADDR_W-1:0] mem_addrB,
    output logic [DATA_W-1:0] mem_dataB,
    input  logic [DATA_W-1:0] mem_qB
`ifdef MEM_FIFO_LEVELS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] CNT_FULL = CNT_W'(DEPTH);

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              data_ok_q;
    logic              data_ok_d;

    mem_fifo_ptr #(
        .WIDTH (ADDR_W)
    ) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (push),
        .ptr     (wr_ptr)
    );

    mem_fifo_ptr #(
        .WIDTH (ADDR_W)
    ) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (pop),
        .ptr     (rd_ptr)
    );

    // wr_ready depends only on registered count, never on rd_ready.
    assign wr_ready = (count_q != CNT_FULL);
    assign rd_valid = (count_q != '0) && data_ok_q;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    // Address port B with the head-to-be so qB lands on it one cycle later.
    assign rd_ptr_next = pop ? (rd_ptr + ADDR_W'(1)) : rd_ptr;

    assign mem_enA   = push;
    assign mem_addrA = wr_ptr;
    assign mem_dataA = wr_data;
    assign mem_enB   = 1'b0;
    assign mem_addrB = rd_ptr_next;
    assign mem_dataB = '0;
    assign rd_data   = mem_qB;
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // The memory returns old data when read and written at one address on the same edge.
    assign data_ok_d = !(push && (wr_ptr == rd_ptr_next));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            data_ok_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
        end
    end

`ifdef MEM_FIFO_LEVELS_EN
    logic almost_full_q;
    logic almost_empty_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (count_d >= CNT_W'(AF_LEVEL));
            almost_empty_q <= (count_d <= CNT_W'(AE_LEVEL));
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl with a behavioural 8x15 memory and a queue reference model.
module tb_mem_fifo_ctrl;

    localparam int unsigned DW = 15;
    localparam int unsigned AW = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready = 1'b0;
    logic [AW:0]   count;
    logic          mem_enA;
    logic [AW-1:0] mem_addrA;
    logic [DW-1:0] mem_dataA;
    logic          mem_enB;
    logic [AW-1:0] mem_addrB;
    logic [DW-1:0] mem_dataB;
    logic [DW-1:0] mem_qB = '0;
`ifdef MEM_FIFO_LEVELS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    always #5 clk = ~clk;

    mem_fifo_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .count     (count),
        .mem_enA   (mem_enA),
        .mem_addrA (mem_addrA),
        .mem_dataA (mem_dataA),
        .mem_enB   (mem_enB),
        .mem_addrB (mem_addrB),
        .mem_dataB (mem_dataB),
        .mem_qB    (mem_qB)
`ifdef MEM_FIFO_LEVELS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // External memory: registered port B read returns old contents on a same-edge write.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_enA) mem[mem_addrA] <= mem_dataA;
        if (mem_enB) mem[mem_addrB] <= mem_dataB;
        mem_qB <= mem[mem_addrB];
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of words plus a flag for a head written on the same edge it became head.
    logic [DW-1:0] q[$];
    bit            stale = 0;

    function automatic bit m_wr_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic bit m_rd_valid();
        return (q.size() != 0) && !stale;
    endfunction

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".count"}, 32'(count), 32'(q.size()));
        check_eq({ctx, ".wr_ready"}, 32'(wr_ready), 32'(m_wr_ready()));
        check_eq({ctx, ".rd_valid"}, 32'(rd_valid), 32'(m_rd_valid()));
        if (m_rd_valid()) check_eq({ctx, ".rd_data"}, 32'(rd_data), 32'(q[0]));
`ifdef MEM_FIFO_LEVELS_EN
        check_eq({ctx, ".almost_full"}, 32'(almost_full), 32'(q.size() >= 6));
        check_eq({ctx, ".almost_empty"}, 32'(almost_empty), 32'(q.size() <= 1));
`endif
    endtask

    // One clock: drive inputs after the falling edge, update the model on the rising edge.
    task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr, input string ctx);
        bit push;
        bit pop;
        int left;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        push = wv && m_wr_ready();
        pop  = rr && m_rd_valid();
        #1;
        check_eq({ctx, ".mem_enA"}, 32'(mem_enA), 32'(push));
        if (push) check_eq({ctx, ".mem_dataA"}, 32'(mem_dataA), 32'(wd));
        @(posedge clk);
        left = q.size() - (pop ? 1 : 0);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(wd);
        stale = push && (left == 0);
        @(negedge clk);
        check_outputs(ctx);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs("reset");
        check_eq("reset.mem_enB", 32'(mem_enB), 32'd0);
        check_eq("reset.mem_dataB", 32'(mem_dataB), 32'd0);

        // Single word fall-through
        cycle(1'b1, 15'h1234, 1'b1, "single");
        check_eq("single.c1_rd_valid", 32'(rd_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, "single");
        check_eq("single.c2_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("single.c2_rd_data", 32'(rd_data), 32'h1234);
        cycle(1'b0, '0, 1'b1, "single");
        check_eq("single.drained", 32'(count), 32'd0);

        // Fill to full, then try pushing while full
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, "fill");
        check_eq("fill.count8", 32'(count), 32'd8);
        cycle(1'b1, 15'h7fff, 1'b0, "full_push");
        cycle(1'b1, 15'h7fff, 1'b1, "full_push_pop");
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, "drain");
        check_eq("drain.empty", 32'(count), 32'd0);

        // Streaming wrap-around
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(i), 1'b1, "stream");
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "stream_tail");

        // Same-address hazard at count=1
        cycle(1'b1, 15'h0555, 1'b0, "hazard_setup");
        cycle(1'b0, '0, 1'b0, "hazard_setup");
        cycle(1'b1, 15'h0aaa, 1'b1, "hazard");
        check_eq("hazard.bubble", 32'(rd_valid), 32'd0);
        cycle(1'b0, '0, 1'b0, "hazard");
        check_eq("hazard.rd_data", 32'(rd_data), 32'h0aaa);
        cycle(1'b0, '0, 1'b1, "hazard_drain");

        // Asynchronous reset mid-stream with five entries
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(15'h100 + i), 1'b0, "prereset");
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        q.delete();
        stale = 0;
        check_eq("async_reset.count", 32'(count), 32'd0);
        check_eq("async_reset.rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs("post_reset");
        cycle(1'b1, 15'h1234, 1'b1, "single2");
        cycle(1'b0, '0, 1'b1, "single2");
        check_eq("single2.rd_data", 32'(rd_data), 32'h1234);
        cycle(1'b0, '0, 1'b1, "single2");

        // Randomised traffic with varying push/pop pressure
        for (int i = 0; i < 600; i++) begin
            int unsigned wp = (i / 150) % 2 == 0 ? 70 : 35;
            int unsigned rp = (i / 150) % 2 == 0 ? 35 : 75;
            cycle($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < rp, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
